// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Requesting end of the program-memory read port. Owns the fetch PC, issues
// one word address per cycle into a memory with a fixed 1-cycle registered
// read latency, and captures returned {word, pc} pairs into a 2-entry queue
// that feeds the decoder over a valid/ready handshake. Branch/jump redirects
// from execute flush the queue and the in-flight word.
//
// Optional feature (compile-time macro IFU_ZERO_HALT_EN):
//   when defined, a pushed word equal to 32'h0 is still delivered but stops
//   all further fetching (halted set, fault untouched).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_addr         read address to program memory (the fetch PC)
//   imem_data/imem_pc word and echoed address returned by memory
//   redirect_valid    single-cycle redirect request from execute
//   redirect_target   new fetch byte address
//   out_valid/ready   decoder handshake for the queue head
//   out_instr/out_pc  queue head word and its PC (zero while empty)
//   fault             sticky: a misaligned redirect target was seen
//   halted            sticky: fetching stopped
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int PC_WIDTH  = 12,
  parameter int OPD_WIDTH = 32,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_data,
  input  logic [OPD_WIDTH-1:0] imem_pc,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [OPD_WIDTH-1:0] out_pc,
  output logic                 fault,
  output logic                 halted
);

  logic [PC_WIDTH-1:0]  fetch_pc;
  logic                 inflight;
  logic [1:0]           count;
  logic [31:0]          q_instr [2];
  logic [OPD_WIDTH-1:0] q_pc    [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic       zero_stop;
  logic       wr_slot;
  logic [2:0] occ;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  // Head registers are not reset; gating keeps the outputs at zero when empty.
  assign out_instr = out_valid ? q_instr[0] : 32'h0;
  assign out_pc    = out_valid ? q_pc[0]    : '0;

  assign pop  = out_valid & out_ready;
  // The word arriving while a redirect is sampled belongs to the old path.
  assign push = inflight & ~redirect_valid;

`ifdef IFU_ZERO_HALT_EN
  // Suppress the issue on the same edge the zero word is captured, so the
  // address after it is never requested.
  assign zero_stop = push & (imem_data == 32'h0);
`else
  assign zero_stop = 1'b0;
`endif

  // Only issue if the word will have a free slot when it returns:
  // occupancy after this edge (count + inflight - pop) must stay below 2.
  assign occ   = {1'b0, count} + {2'b00, inflight};
  assign issue = ~halted & ~redirect_valid & ~zero_stop
               & (occ < (3'd2 + {2'b00, pop}));

  // Slot the incoming word lands in, after any pop shifts the queue down.
  assign wr_slot = ((count - {1'b0, pop}) == 2'd1);

  // Fetch / control stage
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC_WIDTH'(RESET_PC);
      inflight <= 1'b0;
      count    <= 2'd0;
      fault    <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      if (redirect_target[1:0] != 2'b00) begin
        fault  <= 1'b1;
        halted <= 1'b1;
      end else begin
        fetch_pc <= redirect_target;
      end
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + PC_WIDTH'(4);
      count <= count + {1'b0, push} - {1'b0, pop};
      if (zero_stop) halted <= 1'b1;
    end
  end

  // Queue data stage
  always_ff @(posedge clk) begin
    if (pop) begin
      q_instr[0] <= q_instr[1];
      q_pc[0]    <= q_pc[1];
    end
    if (push) begin
      if (wr_slot) begin
        q_instr[1] <= imem_data;
        q_pc[1]    <= imem_pc;
      end else begin
        q_instr[0] <= imem_data;
        q_pc[0]    <= imem_pc;
      end
    end
  end

endmodule
